// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

  // FSM states of the divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Fill bit for the divide-by-zero quotient; replicate to WIDTH for all ones
  localparam logic DIV_ZERO_QUOTIENT = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;

  // Shift in the next dividend bit, subtract the divisor when it fits.
  // The kept remainder is always below the divisor, so WIDTH bits suffice
  // and the subtraction never needs the extra top bit.
  always_comb begin
    shifted      = {rem_in, dividend_bit};
    quotient_bit = (shifted >= {1'b0, divisor});
    rem_out      = shifted[WIDTH-1:0] - (quotient_bit ? divisor : '0);
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring integer divider with signed mode
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic             neg_q;
  logic             neg_r;

  logic             use_signed;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Operand magnitudes and sign bookkeeping for the request being presented
  always_comb begin
    use_signed   = SIGNED_EN & is_signed;
    dividend_neg = use_signed & dividend[WIDTH-1];
    divisor_neg  = use_signed & divisor[WIDTH-1];
    dividend_mag = dividend_neg ? -dividend : dividend;
    divisor_mag  = divisor_neg ? -divisor : divisor;
  end

  // quo_r doubles as the dividend shift register: its MSB feeds the step,
  // and the new quotient bit enters at the LSB.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_r),
    .dividend_bit (quo_r[WIDTH-1]),
    .divisor      (div_r),
    .rem_out      (step_rem),
    .quotient_bit (step_q)
  );

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      div_r     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              // Zero divisor: answer immediately, same in both modes
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              error     <= 1'b1;
              quotient  <= {WIDTH{DIV_ZERO_QUOTIENT}};
              remainder <= dividend;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              done  <= 1'b0;
              error <= 1'b0;
              count <= CW'(WIDTH - 1);
              rem_r <= '0;
              quo_r <= dividend_mag;
              div_r <= divisor_mag;
              neg_q <= dividend_neg ^ divisor_neg;
              neg_r <= dividend_neg;
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        CALC: begin
          rem_r <= step_rem;
          quo_r <= {quo_r[WIDTH-2:0], step_q};
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - CW'(1);
          end
        end
        FIX: begin
          // MIN / -1 wraps back to MIN through the negation, no trap
          quotient  <= neg_q ? -quo_r : quo_r;
          remainder <= neg_r ? -rem_r : rem_r;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
